// File: rtl/riscv_dmem_resp_pkg.sv
// Shared BIU definitions: transfer size encoding plus byte-enable and
// alignment helpers used by the data-memory responder and the LSU.
package riscv_dmem_resp_pkg;

  typedef enum logic [1:0] {
    BYTE  = 2'd0,
    HWORD = 2'd1,
    WORD  = 2'd2,
    DWORD = 2'd3
  } biu_size_t;

  // Byte lanes touched by a transfer of the given size at the given offset.
  function automatic logic [3:0] biu_byte_en(input biu_size_t size, input logic [1:0] adr_lo);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      BYTE:    be = 4'b0001 << adr_lo;
      HWORD:   be = adr_lo[1] ? 4'b1100 : 4'b0011;
      WORD:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // A transfer is misaligned when it is not naturally aligned; DWORD never
  // fits a 32-bit data path and is always rejected.
  function automatic logic biu_misaligned(input biu_size_t size, input logic [1:0] adr_lo);
    logic mis;
    mis = 1'b0;
    case (size)
      BYTE:    mis = 1'b0;
      HWORD:   mis = adr_lo[0];
      WORD:    mis = |adr_lo;
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/riscv_dmem_resp_ram.sv
// Behavioural single-port data SRAM: byte-enable writes, registered read.
// Contents are deliberately not reset so the array maps onto block RAM.
module riscv_dmem_ram #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [XLEN/8-1:0]        be,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [XLEN-1:0]          wdata,
  output logic [XLEN-1:0]          rdata
);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [XLEN-1:0] rdata_q;

  // Byte-lane write port
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int b = 0; b < XLEN/8; b++) begin
        if (be[b]) begin
          mem_q[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  // Registered read; the output holds its value until the next read
  always_ff @(posedge clk) begin
    if (en && !we) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/riscv_dmem_resp.sv
// Data-memory responder: target end of the dmem req/ack interface, serving
// reads and writes from a local tightly-coupled SRAM with a fixed latency.
module riscv_dmem_resp
  import riscv_dmem_resp_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              DEPTH       = 1024,
  parameter logic [XLEN-1:0] BASE_ADDR   = '0,
  parameter int              WAIT_STATES = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dmem_req,
  input  logic            dmem_we,
  input  logic [XLEN-1:0] dmem_adr,
  input  biu_size_t       dmem_size,
  input  logic [XLEN-1:0] dmem_d,
  output logic            dmem_ack,
  output logic [XLEN-1:0] dmem_q,
  output logic            dmem_misaligned,
  output logic            dmem_page_fault
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rd_valid_q, rd_valid_d;
  logic        mis_lat_q, mis_lat_d;
  logic        pf_lat_q, pf_lat_d;
  logic        ack_q, ack_d;
  logic        mis_q, mis_d;
  logic        pf_q, pf_d;

  logic [XLEN:0]   offset;
  logic            in_win;
  logic            req_mis;
  logic            req_pf;
  logic            req_err;
  logic            accept;
  logic            ram_en;
  logic [3:0]      ram_be;
  logic [XLEN-1:0] ram_rdata;

  // One extra bit keeps the window compare unsigned and non-wrapping: a
  // borrow into the top bit means the address lies below the window.
  assign offset  = {1'b0, dmem_adr} - {1'b0, BASE_ADDR};
  assign in_win  = !offset[XLEN] && (offset[XLEN-1:AW+2] == '0);
  assign req_mis = biu_misaligned(dmem_size, offset[1:0]);
  assign req_pf  = !req_mis && !in_win;
  assign req_err = req_mis || !in_win;
  assign accept  = (state_q == S_IDLE) && dmem_req;

  // The SRAM is accessed only in the latch cycle; errors suppress the access
  // and a request seen while reset is held is never committed.
  assign ram_en = accept && !req_err && !rst;
  assign ram_be = biu_byte_en(dmem_size, offset[1:0]);

  riscv_dmem_ram #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (dmem_we),
    .be    (ram_be),
    .addr  (offset[AW+1:2]),
    .wdata (dmem_d),
    .rdata (ram_rdata)
  );

  // Next-state, wait counter, latched transfer status and registered outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_valid_d = rd_valid_q;
    mis_lat_d  = mis_lat_q;
    pf_lat_d   = pf_lat_q;
    case (state_q)
      S_IDLE: begin
        if (dmem_req) begin
          cnt_d      = 4'(WAIT_STATES);
          rd_valid_d = !dmem_we && !req_err;
          mis_lat_d  = req_mis;
          pf_lat_d   = req_pf;
          state_d    = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    ack_d = (state_d == S_RESP);
    mis_d = ack_d && mis_lat_d;
    pf_d  = ack_d && pf_lat_d;
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      mis_lat_q  <= 1'b0;
      pf_lat_q   <= 1'b0;
      ack_q      <= 1'b0;
      mis_q      <= 1'b0;
      pf_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
      mis_lat_q  <= mis_lat_d;
      pf_lat_q   <= pf_lat_d;
      ack_q      <= ack_d;
      mis_q      <= mis_d;
      pf_q       <= pf_d;
    end
  end

  // Read data already sits in the SRAM output register; it is exposed only
  // in the ack cycle of a successful read so dmem_q is zero otherwise.
  assign dmem_q          = (ack_q && rd_valid_q) ? ram_rdata : '0;
  assign dmem_ack        = ack_q;
  assign dmem_misaligned = mis_q;
  assign dmem_page_fault = pf_q;

endmodule

// File: tb/tb_riscv_dmem_resp.sv
// Bench for riscv_dmem_resp: two instances (no wait states / three wait
// states) checked every cycle against a transaction-level model, plus
// directed transfers with hand-computed expectations.
module tb_riscv_dmem_resp;
  import riscv_dmem_resp_pkg::*;

  localparam logic [31:0] BASE0  = 32'h0000_0000;
  localparam logic [31:0] BASE1  = 32'h0000_2000;
  localparam int          DEPTH0 = 1024;
  localparam int          DEPTH1 = 256;
  localparam int          WS0    = 0;
  localparam int          WS1    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req  [2];
  logic        we   [2];
  logic [31:0] adr  [2];
  biu_size_t   size [2];
  logic [31:0] wd   [2];
  logic        ack  [2];
  logic [31:0] q    [2];
  logic        mis  [2];
  logic        pf   [2];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  riscv_dmem_resp #(.XLEN(32), .DEPTH(DEPTH0), .BASE_ADDR(BASE0), .WAIT_STATES(WS0)) u_dut0 (
    .clk(clk), .rst(rst), .dmem_req(req[0]), .dmem_we(we[0]), .dmem_adr(adr[0]),
    .dmem_size(size[0]), .dmem_d(wd[0]), .dmem_ack(ack[0]), .dmem_q(q[0]),
    .dmem_misaligned(mis[0]), .dmem_page_fault(pf[0]));

  riscv_dmem_resp #(.XLEN(32), .DEPTH(DEPTH1), .BASE_ADDR(BASE1), .WAIT_STATES(WS1)) u_dut1 (
    .clk(clk), .rst(rst), .dmem_req(req[1]), .dmem_we(we[1]), .dmem_adr(adr[1]),
    .dmem_size(size[1]), .dmem_d(wd[1]), .dmem_ack(ack[1]), .dmem_q(q[1]),
    .dmem_misaligned(mis[1]), .dmem_page_fault(pf[1]));

  function automatic logic [31:0] base_of(input int d);
    return (d == 0) ? BASE0 : BASE1;
  endfunction
  function automatic int depth_of(input int d);
    return (d == 0) ? DEPTH0 : DEPTH1;
  endfunction
  function automatic int ws_of(input int d);
    return (d == 0) ? WS0 : WS1;
  endfunction

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, d, cyc, act, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  logic [31:0] m_mem   [2][1024];
  bit          m_known [2][1024];
  bit          m_pend  [2];
  int          m_cd    [2];
  logic [31:0] m_q     [2];
  bit          m_mis   [2];
  bit          m_pf    [2];
  bit          m_chkq  [2];

  task automatic model_accept(input int d);
    longint unsigned lo, hi, av;
    int   lane, idx;
    bit   e_mis, e_pf;
    logic [31:0] mask;
    lo   = longint'(base_of(d));
    hi   = lo + longint'(depth_of(d)) * 4;
    av   = longint'(adr[d]);
    lane = int'(av % 4);
    case (size[d])
      BYTE:    e_mis = 1'b0;
      HWORD:   e_mis = (lane % 2) != 0;
      WORD:    e_mis = lane != 0;
      default: e_mis = 1'b1;
    endcase
    e_pf = !e_mis && (av < lo || av >= hi);
    m_mis[d]  = e_mis;
    m_pf[d]   = e_pf;
    m_q[d]    = 32'h0;
    m_chkq[d] = 1'b1;
    if (!e_mis && !e_pf) begin
      idx = int'((av - lo) / 4);
      if (we[d]) begin
        case (size[d])
          BYTE:    mask = 32'h0000_00FF << (8 * lane);
          HWORD:   mask = 32'h0000_FFFF << (8 * lane);
          default: mask = 32'hFFFF_FFFF;
        endcase
        m_mem[d][idx] = (m_mem[d][idx] & ~mask) | (wd[d] & mask);
        if (mask == 32'hFFFF_FFFF) m_known[d][idx] = 1'b1;
      end else begin
        m_q[d]    = m_mem[d][idx];
        m_chkq[d] = m_known[d][idx];
      end
    end
    m_pend[d] = 1'b1;
    m_cd[d]   = 1 + ws_of(d);
  endtask

  task automatic model_step(input int d);
    bit ack_now;
    ack_now = 1'b0;
    if (rst) begin
      m_pend[d] = 1'b0;
      check("rst_ack", d, 32'(ack[d]), 32'h0);
      check("rst_q", d, q[d], 32'h0);
      check("rst_flags", d, {30'h0, mis[d], pf[d]}, 32'h0);
    end else begin
      if (m_pend[d]) begin
        m_cd[d]--;
        if (m_cd[d] == 0) begin
          ack_now   = 1'b1;
          m_pend[d] = 1'b0;
        end
      end
      if (ack_now) begin
        check("ack", d, 32'(ack[d]), 32'h1);
        check("misaligned", d, 32'(mis[d]), 32'(m_mis[d]));
        check("page_fault", d, 32'(pf[d]), 32'(m_pf[d]));
        if (m_chkq[d]) check("q", d, q[d], m_q[d]);
      end else begin
        check("idle_ack", d, 32'(ack[d]), 32'h0);
        check("idle_q", d, q[d], 32'h0);
        check("idle_flags", d, {30'h0, mis[d], pf[d]}, 32'h0);
      end
      if (!m_pend[d] && !ack_now && req[d]) model_accept(d);
    end
  endtask

  always @(negedge clk) begin
    model_step(0);
    model_step(1);
  end

  // ---------------- driver ----------------
  logic [31:0] r_q;
  bit          r_mis, r_pf;
  int          r_lat, r_ac;

  task automatic xfer(input int d, input bit w, input logic [31:0] a, input biu_size_t s,
                      input logic [31:0] data, input bit hold);
    int start;
    bit got;
    @(posedge clk); #1;
    req[d] = 1'b1; we[d] = w; adr[d] = a; size[d] = s; wd[d] = data;
    start = cyc;
    got = 1'b0; r_q = 32'h0; r_mis = 1'b0; r_pf = 1'b0; r_lat = -1; r_ac = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (ack[d]) begin
        got = 1'b1; r_q = q[d]; r_mis = mis[d]; r_pf = pf[d];
        r_lat = cyc - start; r_ac = cyc;
      end
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL ack_timeout dut%0d adr %h: got no ack expected ack within 40 cycles", d, a);
    end
    if (!hold) begin
      @(posedge clk); #1;
      req[d] = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish expected finish");
    $fatal(1);
  end

  initial begin
    int ac0, ac1, nack;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; adr[d] = '0; size[d] = WORD; wd[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Known contents for the first 16 words of both windows
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++)
        xfer(d, 1'b1, base_of(d) + 32'(4 * i), WORD, $urandom, 1'b0);

    // ---- no-wait-state instance, directed ----
    xfer(0, 1'b1, 32'h10, WORD, 32'hDEADBEEF, 1'b0);
    check("wr_lat", 0, 32'(r_lat), 32'd1);
    check("wr_flags", 0, {30'h0, r_mis, r_pf}, 32'h0);
    xfer(0, 1'b0, 32'h10, WORD, 32'h0, 1'b0);
    check("rd_q", 0, r_q, 32'hDEADBEEF);
    check("rd_lat", 0, 32'(r_lat), 32'd1);
    xfer(0, 1'b1, 32'h10, WORD, 32'h11223344, 1'b0);
    xfer(0, 1'b1, 32'h13, BYTE, 32'hAA000000, 1'b0);
    xfer(0, 1'b0, 32'h10, WORD, 32'h0, 1'b0);
    check("byte_merge", 0, r_q, 32'hAA223344);
    xfer(0, 1'b1, 32'h12, HWORD, 32'h55660000, 1'b0);
    xfer(0, 1'b0, 32'h10, WORD, 32'h0, 1'b0);
    check("hword_merge", 0, r_q, 32'h55663344);
    xfer(0, 1'b1, 32'h20, WORD, 32'hCAFEF00D, 1'b0);
    xfer(0, 1'b0, 32'h21, HWORD, 32'h0, 1'b0);
    check("hw_mis_flags", 0, {30'h0, r_mis, r_pf}, 32'h2);
    check("hw_mis_q", 0, r_q, 32'h0);
    xfer(0, 1'b0, 32'h20, WORD, 32'h0, 1'b0);
    check("after_mis", 0, r_q, 32'hCAFEF00D);
    xfer(0, 1'b0, 32'h20, DWORD, 32'h0, 1'b0);
    check("dword_mis", 0, 32'(r_mis), 32'h1);
    xfer(0, 1'b0, 32'h1001, HWORD, 32'h0, 1'b0);
    check("err_priority", 0, {30'h0, r_mis, r_pf}, 32'h2);
    xfer(0, 1'b0, 32'd4096, WORD, 32'h0, 1'b0);
    check("pf_end", 0, {30'h0, r_mis, r_pf}, 32'h1);
    check("pf_end_q", 0, r_q, 32'h0);
    xfer(0, 1'b1, 32'hFFFF_FFFC, WORD, 32'h0BADBAD0, 1'b0);
    check("pf_below", 0, 32'(r_pf), 32'h1);
    xfer(0, 1'b1, 32'h1010, WORD, 32'h12345678, 1'b0);
    check("pf_alias", 0, 32'(r_pf), 32'h1);
    xfer(0, 1'b0, 32'h10, WORD, 32'h0, 1'b0);
    check("no_alias_wr", 0, r_q, 32'h55663344);

    // Write held through reset is never committed
    @(posedge clk); #1;
    rst = 1'b1;
    req[0] = 1'b1; we[0] = 1'b1; adr[0] = 32'h20; size[0] = WORD; wd[0] = 32'hFFFFFFFF;
    repeat (2) @(posedge clk);
    #1 req[0] = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    xfer(0, 1'b0, 32'h20, WORD, 32'h0, 1'b0);
    check("rst_no_write", 0, r_q, 32'hCAFEF00D);

    // ---- three-wait-state instance, directed ----
    xfer(1, 1'b0, BASE1 + 32'h0, WORD, 32'h0, 1'b1);
    check("b2b_lat0", 1, 32'(r_lat), 32'd4);
    ac0 = r_ac;
    xfer(1, 1'b0, BASE1 + 32'h4, WORD, 32'h0, 1'b1);
    check("b2b_lat1", 1, 32'(r_lat), 32'd4);
    check("b2b_period1", 1, 32'(r_ac - ac0), 32'd5);
    ac1 = r_ac;
    xfer(1, 1'b0, BASE1 + 32'h8, WORD, 32'h0, 1'b0);
    check("b2b_period2", 1, 32'(r_ac - ac1), 32'd5);
    xfer(1, 1'b1, BASE1 - 32'd4, WORD, 32'h77777777, 1'b0);
    check("pf_below1", 1, {30'h0, r_mis, r_pf}, 32'h1);
    xfer(1, 1'b1, BASE1 + 32'd1024, WORD, 32'h88888888, 1'b0);
    check("pf_end1", 1, {30'h0, r_mis, r_pf}, 32'h1);
    check("pf_end1_lat", 1, 32'(r_lat), 32'd4);

    // Reset during the wait: no ack, but the latched write stays
    @(posedge clk); #1;
    req[1] = 1'b1; we[1] = 1'b1; adr[1] = BASE1 + 32'h30; size[1] = WORD; wd[1] = 32'h5555AAAA;
    @(posedge clk); #1;
    req[1] = 1'b0;
    rst = 1'b1;
    nack = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ack[1]) nack++;
    end
    @(posedge clk); #1 rst = 1'b0;
    check("rst_no_ack", 1, 32'(nack), 32'd0);
    xfer(1, 1'b0, BASE1 + 32'h30, WORD, 32'h0, 1'b0);
    check("after_rst_q", 1, r_q, 32'h5555AAAA);
    check("after_rst_lat", 1, 32'(r_lat), 32'd4);

    // ---- randomized traffic on both instances ----
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 80; n++) begin
        logic [31:0] a;
        int          sel;
        bit          hold;
        sel = int'($urandom_range(0, 9));
        if (sel < 8)       a = base_of(d) + 32'($urandom_range(0, 63));
        else if (sel == 8) a = base_of(d) + 32'(depth_of(d) * 4) + 32'($urandom_range(0, 63));
        else               a = base_of(d) - 32'($urandom_range(1, 64));
        hold = (n != 79) && ($urandom_range(0, 3) == 0);
        xfer(d, 1'($urandom_range(0, 1)), a, biu_size_t'($urandom_range(0, 3)), $urandom, hold);
        if (!hold && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      end
    end

    repeat (6) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
